// File: rtl/fp_normalizer_if.sv
// Handshake bundle between the adder datapath, the normalizer and the rounder.
// The slave side is the normalizer itself; the master side drives operands and consumes results.
interface fp_normalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic [2:0]  in_frm;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [24:0] out_fraction;
    logic [2:0]  out_frm;
    logic        out_overflow;
    logic        out_underflow;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_frm, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_fraction,
        output out_frm, out_overflow, out_underflow
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_frm, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_fraction,
        input  out_frm, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_normalizer.sv
// Post-add normalizer: one-bit right shift on carry-out, iterative left shift
// until the hidden bit is set or the exponent bottoms out at the denormal range.
module fp_normalizer (
    input  logic           CLK,
    input  logic           nRST,
    fp_normalizer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state, w_state;
    logic        r_sign,  w_sign;
    logic [7:0]  r_exp,   w_exp;
    logic [26:0] r_mant,  w_mant;
    logic [2:0]  r_frm,   w_frm;
    logic        r_o_sign, w_o_sign;
    logic [7:0]  r_o_exp,  w_o_exp;
    logic [24:0] r_o_frac, w_o_frac;
    logic [2:0]  r_o_frm,  w_o_frm;
    logic        r_o_ovf,  w_o_ovf;
    logic        r_o_unf,  w_o_unf;
    logic [24:0] w_rsh;

    // Sticky folds in the old guard so no discarded bit is lost.
    assign w_rsh = {r_mant[25:3], r_mant[2], r_mant[1] | r_mant[0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_exp    <= 8'd0;
            r_mant   <= 27'd0;
            r_frm    <= 3'd0;
            r_o_sign <= 1'b0;
            r_o_exp  <= 8'd0;
            r_o_frac <= 25'd0;
            r_o_frm  <= 3'd0;
            r_o_ovf  <= 1'b0;
            r_o_unf  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sign   <= w_sign;
            r_exp    <= w_exp;
            r_mant   <= w_mant;
            r_frm    <= w_frm;
            r_o_sign <= w_o_sign;
            r_o_exp  <= w_o_exp;
            r_o_frac <= w_o_frac;
            r_o_frm  <= w_o_frm;
            r_o_ovf  <= w_o_ovf;
            r_o_unf  <= w_o_unf;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_sign   = r_sign;
        w_exp    = r_exp;
        w_mant   = r_mant;
        w_frm    = r_frm;
        w_o_sign = r_o_sign;
        w_o_exp  = r_o_exp;
        w_o_frac = r_o_frac;
        w_o_frm  = r_o_frm;
        w_o_ovf  = r_o_ovf;
        w_o_unf  = r_o_unf;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_sign  = bus.in_sign;
                    w_exp   = bus.in_exp;
                    w_mant  = bus.in_mant;
                    w_frm   = bus.in_frm;
                    w_state = SHIFT;
                end
            end
            SHIFT: begin
                w_o_sign = r_sign;
                w_o_frm  = r_frm;
                w_o_ovf  = 1'b0;
                w_o_unf  = 1'b0;
                w_state  = DONE;
                // Exponent only decreases while here, so 255 means 255 at capture.
                if (r_mant == 27'd0) begin
                    w_o_exp  = 8'd0;
                    w_o_frac = 25'd0;
                end else if (r_exp == 8'hFF) begin
                    w_o_exp  = 8'hFF;
                    w_o_frac = r_mant[24:0];
                end else if (r_mant[26]) begin
                    if (r_exp == 8'hFE) begin
                        w_o_exp  = 8'hFF;
                        w_o_frac = 25'd0;
                        w_o_ovf  = 1'b1;
                    end else begin
                        w_o_exp  = r_exp + 8'd1;
                        w_o_frac = w_rsh;
                    end
                end else if (r_mant[25]) begin
                    w_o_exp  = (r_exp == 8'd0) ? 8'd1 : r_exp;
                    w_o_frac = r_mant[24:0];
                end else if (r_exp > 8'd1) begin
                    w_mant  = {r_mant[25:0], 1'b0};
                    w_exp   = r_exp - 8'd1;
                    w_state = SHIFT;
                end else begin
                    w_o_exp  = 8'd0;
                    w_o_frac = r_mant[24:0];
                    w_o_unf  = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_sign      = r_o_sign;
    assign bus.out_exp       = r_o_exp;
    assign bus.out_fraction  = r_o_frac;
    assign bus.out_frm       = r_o_frm;
    assign bus.out_overflow  = r_o_ovf;
    assign bus.out_underflow = r_o_unf;
endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized bench for fp_normalizer against an arithmetic reference model,
// plus the directed corner vectors and a mid-operation reset.
module tb_fp_normalizer;
    logic CLK = 1'b0;
    logic nRST;
    int   n_chk  = 0;
    int   n_fail = 0;

    fp_normalizer_if bus ();

    fp_normalizer dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros, clamp shifts by exponent headroom.
    task automatic model(input logic [7:0] e, input logic [26:0] m,
                         output logic [7:0] oe, output logic [24:0] of,
                         output logic ov, output logic un, output int n);
        int ei, p, d, avail;
        logic [26:0] sm;
        logic [26:0] rs;
        ei = e;
        ov = 1'b0;
        un = 1'b0;
        n  = 0;
        if (m == 27'd0) begin
            oe = 8'd0;
            of = 25'd0;
        end else if (ei == 255) begin
            oe = 8'hFF;
            of = m[24:0];
        end else if (m >= 27'h4000000) begin
            rs = (m >> 1) | {26'd0, m[0]};
            if (ei + 1 == 255) begin
                oe = 8'hFF;
                of = 25'd0;
                ov = 1'b1;
            end else begin
                oe = 8'(ei + 1);
                of = rs[24:0];
            end
        end else begin
            p = 0;
            for (int i = 0; i < 26; i++) if (m[i]) p = i;
            d = 25 - p;
            avail = (ei > 1) ? ei - 1 : 0;
            n = (d < avail) ? d : avail;
            sm = m << n;
            of = sm[24:0];
            if (n == d) begin
                oe = (ei - d < 1) ? 8'd1 : 8'(ei - d);
            end else begin
                oe = 8'd0;
                un = 1'b1;
            end
        end
    endtask

    task automatic chk_out(input logic s, input logic [7:0] e,
                           input logic [24:0] f, input logic [2:0] r,
                           input logic ov, input logic un);
        chk("sign", bus.out_sign, s);
        chk("exp", bus.out_exp, e);
        chk("frac", bus.out_fraction, f);
        chk("frm", bus.out_frm, r);
        chk("ovf", bus.out_overflow, ov);
        chk("unf", bus.out_underflow, un);
    endtask

    task automatic run_op(input logic s, input logic [7:0] e,
                          input logic [26:0] m, input logic [2:0] r,
                          input int hold);
        logic [7:0]  oe;
        logic [24:0] of;
        logic        ov, un;
        int          n, cyc;
        model(e, m, oe, of, ov, un, n);
        @(negedge CLK);
        chk("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_frm   = r;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.in_mant  = $urandom;
        bus.in_exp   = $urandom;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        chk("latency", cyc, n + 1);
        chk_out(s, oe, of, r, ov, un);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_ready", bus.in_ready, 1'b0);
            chk("hold_exp", bus.out_exp, oe);
            chk("hold_frac", bus.out_fraction, of);
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        bus.out_ready = 1'b0;
        chk("drain_valid", bus.out_valid, 1'b0);
        chk("drain_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] mr;
        logic [7:0]  er;
        int          k, seen;
        nRST          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd0;
        bus.in_mant   = 27'd0;
        bus.in_frm    = 3'd0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk_out(1'b0, 8'd0, 25'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        run_op(1'b0, 8'h80, 27'h2000000, 3'b000, 0);
        run_op(1'b1, 8'h7F, 27'h4000003, 3'b010, 1);
        run_op(1'b0, 8'hFE, 27'h4000000, 3'b001, 0);
        run_op(1'b0, 8'h90, 27'h0000004, 3'b100, 2);
        run_op(1'b0, 8'h03, 27'h0400000, 3'b011, 0);
        run_op(1'b1, 8'h45, 27'h0000000, 3'b000, 5);
        run_op(1'b0, 8'hFF, 27'h1234567, 3'b111, 0);
        run_op(1'b0, 8'h00, 27'h2000001, 3'b000, 0);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0: er = 8'd0;
                1: er = 8'd1;
                2: er = 8'd2;
                3: er = 8'hFE;
                4: er = 8'hFF;
                default: er = 8'($urandom);
            endcase
            k = $urandom_range(0, 28);
            if (k == 28) mr = 32'd0;
            else if (k == 27) mr = $urandom & 32'h7FFFFFF;
            else mr = (32'd1 << k) | ($urandom & ((32'd1 << k) - 32'd1));
            run_op(1'($urandom), er, mr[26:0], 3'($urandom),
                   $urandom_range(0, 5));
        end

        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 8'h90;
        bus.in_mant  = 27'h0000020;
        bus.in_frm   = 3'b101;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        chk_out(1'b0, 8'd0, 25'd0, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.out_valid) seen++;
        end
        chk("no_output_after_rst", seen, 0);
        run_op(1'b0, 8'h80, 27'h2000000, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1: unnormalized operand present.
REQ-004 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-005 SHALL have port in_sign, input, 1: result sign.
REQ-006 SHALL have port in_exp, input, 8: biased exponent.
REQ-007 SHALL have port in_mant, input, 27: [26] carry-out, [25] hidden-bit position, [24:2] fraction, [1] guard, [0] sticky.
REQ-008 SHALL have port in_frm, input, 3: rounding mode, passed through unchanged.
REQ-009 SHALL have port out_valid, output, 1: normalized result held.
REQ-010 SHALL have port out_ready, input, 1: downstream rounder consumes the result.
REQ-011 SHALL have ports out_sign (1), out_exp (8), out_fraction (25: [24:2] mantissa, [1:0] round bits) and out_frm (3), all outputs, forming the rounder input word.
REQ-012 SHALL have ports out_overflow and out_underflow, outputs, 1 each: exponent saturated to 255, or result denormal/nonzero.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE; in_ready = (state == IDLE), combinational.
REQ-014 In IDLE with in_valid=1, SHALL capture sign/exp/mant/frm into working registers and go to SHIFT (acceptance edge k).
REQ-015 In SHIFT, if mant==0, SHALL go to DONE with exp=0, fraction=0, sign preserved, both flags 0.
REQ-016 In SHIFT, if exp==255 at capture, SHALL go to DONE with the operand passed through unshifted (inf/NaN), flags 0.
REQ-017 In SHIFT, if mant[26]==1, SHALL right-shift once: new[25:2]=old[26:3], new[1]=old[2], new[0]=old[1]|old[0], exp+1; then go to DONE.
REQ-018 If the REQ-017 increment yields exp==255, SHALL output exp=255, fraction=0 and out_overflow=1.
REQ-019 In SHIFT, if mant[26]==0, mant[25]==0 and exp>1, SHALL left-shift mant by one, shifting 0 into bit 0, decrement exp, and remain in SHIFT.
REQ-020 In SHIFT, if mant[25]==1, SHALL go to DONE with out_exp = max(exp,1); an operand captured with exp=0 therefore outputs exp=1.
REQ-021 In SHIFT, if mant[25]==0 and exp<=1 with mant nonzero, SHALL go to DONE with out_exp=0, fraction=mant[24:0] and out_underflow=1.
REQ-022 Latency SHALL be out_valid high after edge k+1+n, where n = number of left shifts (0..25); right-shift, zero and pass-through cases have n=0.
REQ-023 In DONE, out_valid=1 and all out_* SHALL hold stable until out_ready=1; on that edge the block SHALL return to IDLE with out_valid=0.
REQ-024 The block SHALL NOT accept a new operand in the DONE-handshake cycle; at most one operand is in flight, and throughput is one per n+3 cycles.
REQ-025 out_* data SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-026 nRST low SHALL immediately force state=IDLE, out_valid=0, out_sign=0, out_exp=0, out_fraction=0, out_frm=0 and both flags 0; in_ready=1.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL discard the in-flight operand, with no output produced after release.

Verification
REQ-028 in_exp=0x80, in_mant=0x2000000, frm=000 -> out_valid after k+1, out_exp=0x80, out_fraction=0x0000000, flags 0.
REQ-029 in_exp=0x7F, in_mant=0x4000003 -> out_valid after k+1, out_exp=0x80, out_fraction=0x0000001; in_exp=0xFE, in_mant=0x4000000 -> out_exp=0xFF, fraction 0, out_overflow=1.
REQ-030 in_exp=0x90, in_mant=0x0000004 -> 23 shifts, out_valid after k+24, out_exp=0x79, out_fraction=0x0000000.
REQ-031 in_exp=0x03, in_mant=0x0400000 -> 2 shifts, out_exp=0x00, out_fraction=0x1000000, out_underflow=1; in_mant=0, sign=1 -> out_exp=0, out_fraction=0, out_sign=1.
REQ-032 out_ready held low 5 cycles in DONE -> outputs and out_valid stable, in_ready=0 throughout; nRST pulsed low during a 20-shift operation -> out_valid=0 and in_ready=1 immediately, no result emitted.
